// File: rtl/instr_encoder.sv
// instr_encoder
//   Builds RV32I instruction words from field-level requests and streams them
//   to an instruction-memory write port at sequential word addresses starting
//   at BASE_ADDR. Requests with an out-of-range immediate are consumed, flagged
//   on the sticky err output, and produce no word.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clr             synchronous clear of count/err/done, drops a pending word
//   in_valid/ready  request handshake
//   fmt             0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 JAL, 7 JALR
//   funct3, funct7b5, rd, rs1, rs2, imm   instruction fields
//   out_valid/ready write-port handshake
//   wr_addr, wr_data  word address and encoded instruction
//   count           words written so far
//   done            DEPTH words written
//   err             sticky illegal-immediate flag
//
// state  | meaning
// S_RUN  | accepting; output register empty or draining this cycle
// S_HOLD | output word stalled by the memory
// S_DONE | DEPTH words written; no further requests until clr
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000,
  parameter int                    DEPTH      = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   fmt,
  input  logic [2:0]                   funct3,
  input  logic                         funct7b5,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [31:0]                  imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [31:0]                  wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic                         err
);

  localparam int           CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]  DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST   = CW'(DEPTH-1);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_out_valid;
  logic [31:0]           r_wr_data;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [CW-1:0]         r_count;
  logic                  r_err;

  logic                  w_fire_out, w_accept, w_room, w_legal, w_is_shift;
  logic                  w_fits12, w_fits13, w_fits21;
  logic [31:0]           w_enc;
  logic [CW-1:0]         w_slot;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // Words already committed (written + pending) must stay below DEPTH before
  // another request is taken, so the DEPTH-th word is the last one ever emitted.
  assign w_room     = ({1'b0, r_count} + {{CW{1'b0}}, r_out_valid}) < DEPTH_W;
  assign in_ready   = (r_state != S_DONE) && (!r_out_valid || out_ready) && w_room;
  assign w_fire_out = r_out_valid && out_ready;
  assign w_accept   = in_valid && in_ready && !clr;

  // A word accepted while the previous one drains lands at the next slot.
  assign w_slot     = r_count + CW'(w_fire_out);
  assign w_addr_nxt = BASE_ADDR + (ADDR_WIDTH'(w_slot) << 2);

  // Sign-extension checks: the bits above the field must all match the sign.
  assign w_fits12   = (&imm[31:11]) || !(|imm[31:11]);
  assign w_fits13   = (&imm[31:12]) || !(|imm[31:12]);
  assign w_fits21   = (&imm[31:20]) || !(|imm[31:20]);
  assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    w_enc   = '0;
    w_legal = 1'b0;
    case (fmt)
      3'd0: begin
        w_enc   = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
        w_legal = 1'b1;
      end
      3'd1: begin
        if (w_is_shift) begin
          w_enc   = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
          w_legal = !(|imm[31:5]);
        end else begin
          w_enc   = {imm[11:0], rs1, funct3, rd, 7'b0010011};
          w_legal = w_fits12;
        end
      end
      3'd2: begin
        w_enc   = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        w_legal = w_fits12;
      end
      3'd3: begin
        w_enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        w_legal = w_fits12;
      end
      3'd4: begin
        w_enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        w_legal = w_fits13 && !imm[0];
      end
      3'd5: begin
        w_enc   = {imm[31:12], rd, 7'b0110111};
        w_legal = !(|imm[11:0]);
      end
      3'd6: begin
        w_enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        w_legal = w_fits21 && !imm[0];
      end
      3'd7: begin
        w_enc   = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        w_legal = w_fits12;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_DONE: w_state_nxt = S_DONE;
        default: begin
          if (w_fire_out && (r_count == LAST))
            w_state_nxt = S_DONE;
          else if (r_out_valid && !out_ready)
            w_state_nxt = S_HOLD;
          else
            w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= BASE_ADDR;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_fire_out)
        r_count <= r_count + CW'(1);
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_wr_data   <= w_enc;
        r_wr_addr   <= w_addr_nxt;
      end else if (w_fire_out) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && !w_legal)
        r_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign wr_data   = r_wr_data;
  assign wr_addr   = r_wr_addr;
  assign count     = r_count;
  assign err       = r_err;
  assign done      = (r_state == S_DONE);

endmodule
